// File: rtl/wb_store_buffer_pkg.sv
// Shared definitions for the writeback store buffer: size codes, ptcid width and
// the field layout of the packed {ptcid,size,addr,data} entry word.
package wb_store_buffer_pkg;
  localparam int PTCID_W = 7;
  localparam int SIZE_W  = 2;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_W = 2'b01,
    SZ_D = 2'b10,
    SZ_Q = 2'b11
  } sz_e;

  // Data sits in the low bits so the head mux can slice fields with constant offsets.
  function automatic int ent_w(input int aw, input int dw);
    return PTCID_W + SIZE_W + aw + dw;
  endfunction

  function automatic int off_addr(input int dw);
    return dw;
  endfunction

  function automatic int off_size(input int aw, input int dw);
    return dw + aw;
  endfunction

  function automatic int off_ptcid(input int aw, input int dw);
    return dw + aw + SIZE_W;
  endfunction
endpackage

// File: rtl/wb_stbuf_entry.sv
// One registered store-buffer slot: valid bit plus packed entry word.
// With WB_STBUF_FWD_EN defined it also reports an exact addr/size match for forwarding.
module wb_stbuf_entry
  import wb_store_buffer_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int EW = ent_w(AW, DW)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic          clear,
  input  logic [EW-1:0] wr_word,
  output logic          valid,
  output logic [EW-1:0] word
`ifdef WB_STBUF_FWD_EN
  ,
  input  logic [AW-1:0] lk_addr,
  input  logic [1:0]    lk_size,
  output logic          match
`endif
);

  always_ff @(posedge clk) begin
    if (!clr) begin
      valid <= 1'b0;
      word  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= wr_word;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

`ifdef WB_STBUF_FWD_EN
  // Exact match only; partially overlapping stores never forward.
  assign match = valid
              && (word[off_addr(DW) +: AW] == lk_addr)
              && (word[off_size(AW, DW) +: SIZE_W] == lk_size);
`endif

endmodule

// File: rtl/wb_store_buffer.sv
// In-order store buffer between writeback and the mem-stage writeback port.
// Optional store-to-load forwarding lookup enabled by defining WB_STBUF_FWD_EN.
module wb_store_buffer
  import wb_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic [1:0]               in_size,
  input  logic [PTCID_W-1:0]       in_ptcid,
  output logic                     in_full,
  input  logic                     wbaq_isfull,
  output logic                     wb_valid,
  output logic [AW-1:0]            wb_memaddr,
  output logic [DW-1:0]            wb_memdata,
  output logic [1:0]               wb_size,
  output logic [PTCID_W-1:0]       wb_ptcid,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef WB_STBUF_FWD_EN
  ,
  input  logic [AW-1:0]            lk_addr,
  input  logic [1:0]               lk_size,
  output logic                     lk_hit,
  output logic [DW-1:0]            lk_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ent_w(AW, DW);

  logic [PW-1:0]             rd_ptr, wr_ptr;
  logic [CW-1:0]             cnt;
  logic                      enq, deq;
  logic [EW-1:0]             in_word, head;
  logic [DEPTH-1:0]          ent_vld;
  logic [DEPTH-1:0][EW-1:0]  ent_word;

  assign in_full  = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign wb_valid = ~empty & ~wbaq_isfull;
  assign enq      = in_valid & ~in_full;
  assign deq      = wb_valid;
  assign in_word  = {in_ptcid, in_size, in_addr, in_data};

  // Power-of-two depth lets the pointers wrap naturally; cnt tells full from empty.
  always_ff @(posedge clk) begin
    if (!clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef WB_STBUF_FWD_EN
  logic [DEPTH-1:0] ent_match;
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    wb_stbuf_entry #(.AW(AW), .DW(DW), .EW(EW)) u_ent (
      .clk     (clk),
      .clr     (clr),
      .load    (enq && (wr_ptr == PW'(g))),
      .clear   (deq && (rd_ptr == PW'(g))),
      .wr_word (in_word),
      .valid   (ent_vld[g]),
      .word    (ent_word[g])
`ifdef WB_STBUF_FWD_EN
      ,
      .lk_addr (lk_addr),
      .lk_size (lk_size),
      .match   (ent_match[g])
`endif
    );
  end

  // Head slot is valid exactly when the buffer is non-empty; gate so outputs read zero when empty.
  assign head       = ent_vld[rd_ptr] ? ent_word[rd_ptr] : '0;
  assign wb_memdata = head[DW-1:0];
  assign wb_memaddr = head[off_addr(DW) +: AW];
  assign wb_size    = head[off_size(AW, DW) +: SIZE_W];
  assign wb_ptcid   = head[off_ptcid(AW, DW) +: PTCID_W];

`ifdef WB_STBUF_FWD_EN
  logic [PW-1:0] lk_idx;

  // Walk oldest to youngest so the last hit seen is the youngest matching store.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    lk_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = rd_ptr + PW'(i);
      if (ent_match[lk_idx]) begin
        lk_hit  = 1'b1;
        lk_data = ent_word[lk_idx][DW-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_store_buffer.sv
// Directed self-checking bench for wb_store_buffer (DEPTH=4, AW=32, DW=64).
module tb_wb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 64;

  logic          clk = 1'b0;
  logic          clr;
  logic          in_valid;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic [1:0]    in_size;
  logic [6:0]    in_ptcid;
  logic          in_full;
  logic          wbaq_isfull;
  logic          wb_valid;
  logic [AW-1:0] wb_memaddr;
  logic [DW-1:0] wb_memdata;
  logic [1:0]    wb_size;
  logic [6:0]    wb_ptcid;
  logic          empty;
  logic [2:0]    count;
`ifdef WB_STBUF_FWD_EN
  logic [AW-1:0] lk_addr;
  logic [1:0]    lk_size;
  logic          lk_hit;
  logic [DW-1:0] lk_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .in_size(in_size), .in_ptcid(in_ptcid), .in_full(in_full), .wbaq_isfull(wbaq_isfull),
    .wb_valid(wb_valid), .wb_memaddr(wb_memaddr), .wb_memdata(wb_memdata), .wb_size(wb_size),
    .wb_ptcid(wb_ptcid), .empty(empty), .count(count)
`ifdef WB_STBUF_FWD_EN
    , .lk_addr(lk_addr), .lk_size(lk_size), .lk_hit(lk_hit), .lk_data(lk_data)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [63:0] d,
                       input logic [1:0] s, input logic [6:0] p);
    in_valid = v; in_addr = a; in_data = d; in_size = s; in_ptcid = p;
  endtask

  initial begin
    clr = 1'b0; wbaq_isfull = 1'b0;
    drive(1'b1, 32'h0000_0040, 64'h55, 2'b11, 7'd9);
`ifdef WB_STBUF_FWD_EN
    lk_addr = '0; lk_size = '0;
`endif
    #1;
    // 1: reset held two cycles with in_valid asserted
    tick(); tick();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_in_full", 64'(in_full), 64'd0);
    chk("rst_addr", 64'(wb_memaddr), 64'd0);
    chk("rst_data", wb_memdata, 64'd0);
    chk("rst_size", 64'(wb_size), 64'd0);
    chk("rst_ptcid", 64'(wb_ptcid), 64'd0);

    // 2: single store, no same-cycle bypass
    clr = 1'b1;
    drive(1'b1, 32'h0000_1000, 64'hDEAD_BEEF, 2'b10, 7'd5);
    #1;
    chk("single_nobypass", 64'(wb_valid), 64'd0);
    tick();
    drive(1'b0, '0, '0, 2'b00, '0);
    #1;
    chk("single_valid", 64'(wb_valid), 64'd1);
    chk("single_addr", 64'(wb_memaddr), 64'h1000);
    chk("single_data", wb_memdata, 64'hDEAD_BEEF);
    chk("single_size", 64'(wb_size), 64'd2);
    chk("single_ptcid", 64'(wb_ptcid), 64'd5);
    chk("single_count", 64'(count), 64'd1);
    tick();
    chk("single_empty", 64'(empty), 64'd1);
    chk("single_drained", 64'(wb_valid), 64'd0);

    // 3: fill while blocked, 5th store refused, then drain in order
    wbaq_isfull = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 8), 64'hA0 + 64'(i), 2'b11, 7'(i));
      tick();
    end
    chk("fill_full", 64'(in_full), 64'd1);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_blocked", 64'(wb_valid), 64'd0);
    drive(1'b1, 32'h900, 64'hBAD, 2'b11, 7'd99);
    tick();
    chk("fill_5th_count", 64'(count), 64'd4);
    drive(1'b0, '0, '0, 2'b00, '0);
    wbaq_isfull = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 64'(wb_valid), 64'd1);
      chk("drain_data", wb_memdata, 64'hA0 + 64'(i));
      chk("drain_addr", 64'(wb_memaddr), 64'h100 + 64'(i * 8));
      chk("drain_ptcid", 64'(wb_ptcid), 64'(i));
      tick();
    end
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_no5th", 64'(wb_valid), 64'd0);

    // 4: backpressure pattern 1,0,1,1,0 with 3 queued -> 2 dequeues
    wbaq_isfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 64'hB0 + 64'(i), 2'b00, 7'd1);
      tick();
    end
    drive(1'b0, '0, '0, 2'b00, '0);
    begin
      logic [4:0] pat;
      int h;
      pat = 5'b01101;  // applied LSB first: 1,0,1,1,0
      h = 0;
      for (int k = 0; k < 5; k++) begin
        wbaq_isfull = pat[k];
        #1;
        chk("bp_valid", 64'(wb_valid), 64'(!pat[k]));
        chk("bp_head", wb_memdata, 64'hB0 + 64'(h));
        tick();
        if (!pat[k]) h++;
      end
    end
    chk("bp_count", 64'(count), 64'd1);
    chk("bp_last", wb_memdata, 64'hB2);
    wbaq_isfull = 1'b0;
    tick();
    chk("bp_empty", 64'(empty), 64'd1);

    // 5: simultaneous enq/deq at count=2, pointers wrap
    wbaq_isfull = 1'b1;
    drive(1'b1, 32'h300, 64'hC0, 2'b01, 7'd2); tick();
    drive(1'b1, 32'h308, 64'hC1, 2'b01, 7'd2); tick();
    wbaq_isfull = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h310 + 32'(k * 8), 64'hC2 + 64'(k), 2'b01, 7'd2);
      #1;
      chk("sim_count", 64'(count), 64'd2);
      chk("sim_head", wb_memdata, 64'hC0 + 64'(k));
      tick();
    end
    drive(1'b0, '0, '0, 2'b00, '0);
    #1;
    chk("sim_count_end", 64'(count), 64'd2);
    chk("sim_tail0", wb_memdata, 64'hC6);
    tick();
    chk("sim_tail1", wb_memdata, 64'hC7);
    tick();
    chk("sim_empty", 64'(empty), 64'd1);

    // 6: reset while draining
    wbaq_isfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400 + 32'(i), 64'hD0 + 64'(i), 2'b11, 7'd3);
      tick();
    end
    drive(1'b0, '0, '0, 2'b00, '0);
    wbaq_isfull = 1'b0;
    tick();
    chk("mid_count", 64'(count), 64'd2);
    clr = 1'b0;
    tick();
    clr = 1'b1;
    #1;
    chk("mid_empty", 64'(empty), 64'd1);
    chk("mid_valid", 64'(wb_valid), 64'd0);
    chk("mid_count0", 64'(count), 64'd0);
    chk("mid_data0", wb_memdata, 64'd0);

`ifdef WB_STBUF_FWD_EN
    wbaq_isfull = 1'b1;
    drive(1'b1, 32'h2000, 64'd1, 2'b11, 7'd4); tick();
    drive(1'b1, 32'h2000, 64'd2, 2'b11, 7'd4); tick();
    drive(1'b0, '0, '0, 2'b00, '0);
    lk_addr = 32'h2000; lk_size = 2'b11;
    #1;
    chk("fwd_hit", 64'(lk_hit), 64'd1);
    chk("fwd_data", lk_data, 64'd2);
    lk_size = 2'b10;
    #1;
    chk("fwd_size_miss", 64'(lk_hit), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
